conv_frame_loader: RTL

Upstream feeder for the 3x3 naive convolution engine. It receives one frame as a serial valid/ready stream: 9 quantized weights, then 25 input-map pixels, both row-major. It assembles them into the engine's weights/inputMAP registers, pulses the engine start and holds both registers stable until the engine reports completion. Weights can be kept from the previous frame so only the 25 pixels are streamed.

---
 rtl/conv_frame_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/conv_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_loader
// Description : Serial valid/ready frame loader for the 3x3 convolution
//               engine. Captures 9 weights and 25 pixels (row-major) into
//               the engine's packed weights/inputMAP registers, pulses
//               conv_start and holds the registers until conv_done rises.
//               Stored weights can be reused so only pixels are streamed.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_loader #(
    parameter int ELEM_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [ELEM_W-1:0]    s_data,
    input  logic                 s_last,
    input  logic                 keep_weights,
    output logic [25*ELEM_W-1:0] inputMAP,
    output logic [9*ELEM_W-1:0]  weights,
    output logic                 conv_start,
    input  logic                 conv_done,
    output logic                 busy,
    output logic                 frame_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_X = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_W_IDX = 5'd8;
    localparam logic [4:0] LAST_X_IDX = 5'd24;

    state_t             state;
    state_t             state_n;
    logic [4:0]         idx;
    logic [4:0]         idx_n;
    logic               weights_loaded;
    logic               weights_loaded_n;
    // Set while the current frame carries freshly streamed weights; an early
    // s_last in the pixel phase then invalidates them.
    logic               fresh;
    logic               fresh_n;
    logic               frame_err_n;
    logic               done_prev;
    logic               accept;
    logic               done_rise;
    logic               wr_w;
    logic               wr_x;
    logic [ELEM_W-1:0]  wmem [0:8];
    logic [ELEM_W-1:0]  xmem [0:24];

    assign s_ready    = (state == S_LOAD_W) || (state == S_LOAD_X);
    assign accept     = s_valid && s_ready;
    assign conv_start = (state == S_START);
    assign busy       = (state != S_IDLE);
    assign done_rise  = conv_done && !done_prev;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, index, error and write-enable decode.
    always_comb begin
        state_n          = state;
        idx_n            = idx;
        weights_loaded_n = weights_loaded;
        fresh_n          = fresh;
        frame_err_n      = 1'b0;
        wr_w             = 1'b0;
        wr_x             = 1'b0;
        case (state)
            S_IDLE: begin
                idx_n = 5'd0;
                if (s_valid) begin
                    if (keep_weights && weights_loaded) begin
                        state_n = S_LOAD_X;
                        fresh_n = 1'b0;
                    end else begin
                        state_n = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (accept) begin
                    wr_w = 1'b1;
                    if (s_last) begin
                        frame_err_n      = 1'b1;
                        state_n          = S_IDLE;
                        idx_n            = 5'd0;
                        weights_loaded_n = 1'b0;
                    end else if (idx == LAST_W_IDX) begin
                        state_n          = S_LOAD_X;
                        idx_n            = 5'd0;
                        weights_loaded_n = 1'b1;
                        fresh_n          = 1'b1;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            S_LOAD_X: begin
                if (accept) begin
                    wr_x = 1'b1;
                    if (idx == LAST_X_IDX) begin
                        idx_n = 5'd0;
                        if (s_last) begin
                            state_n = S_START;
                        end else begin
                            // Pixels are complete, so the weights stay valid.
                            frame_err_n = 1'b1;
                            state_n     = S_IDLE;
                        end
                    end else if (s_last) begin
                        frame_err_n = 1'b1;
                        state_n     = S_IDLE;
                        idx_n       = 5'd0;
                        if (fresh) begin
                            weights_loaded_n = 1'b0;
                        end
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            S_START: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Control registers and element capture on accepted beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= 5'd0;
            weights_loaded <= 1'b0;
            fresh          <= 1'b0;
            frame_err      <= 1'b0;
            done_prev      <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                wmem[k] <= '0;
            end
            for (int k = 0; k < 25; k++) begin
                xmem[k] <= '0;
            end
        end else begin
            idx            <= idx_n;
            weights_loaded <= weights_loaded_n;
            fresh          <= fresh_n;
            frame_err      <= frame_err_n;
            done_prev      <= conv_done;
            if (wr_w) begin
                wmem[idx[3:0]] <= s_data;
            end
            if (wr_x) begin
                xmem[idx] <= s_data;
            end
        end
    end

    // Element k sits at bits [k*ELEM_W +: ELEM_W] of the packed buses.
    genvar gk;
    generate
        for (gk = 0; gk < 9; gk++) begin : g_pack_w
            assign weights[gk*ELEM_W +: ELEM_W] = wmem[gk];
        end
        for (gk = 0; gk < 25; gk++) begin : g_pack_x
            assign inputMAP[gk*ELEM_W +: ELEM_W] = xmem[gk];
        end
    endgenerate

endmodule
`default_nettype wire
